// File: rtl/register_file_16bit_32size_pkg.sv
// Shared widths and types for the 32 x 16-bit register file.
package regfile_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Whole register array flattened into one vector, register 0 in the low bits.
    typedef logic [DEPTH*DATA_W-1:0] reg_flat_t;

endpackage

// File: rtl/register_file_16bit_32size_if.sv
// Datapath-side bus of the register file: write controls, two read addresses, two read results.
interface register_file_16bit_32size_if;
    import regfile_pkg::*;

    logic      mode;
    reg_addr_t write_address;
    reg_data_t write_value;
    reg_addr_t read_address1;
    reg_addr_t read_address2;
    reg_data_t read_value1;
    reg_data_t read_value2;

    // Decode/ALU side.
    modport master (
        output mode,
        output write_address,
        output write_value,
        output read_address1,
        output read_address2,
        input  read_value1,
        input  read_value2
    );

    // Register file side.
    modport slave (
        input  mode,
        input  write_address,
        input  write_value,
        input  read_address1,
        input  read_address2,
        output read_value1,
        output read_value2
    );

endinterface

// File: rtl/register_file_16bit_32size_read_port.sv
// One combinational read port: DEPTH:1 mux of DATA_W-bit words.
module regfile_read_port
    import regfile_pkg::*;
(
    input  reg_flat_t arrayFlat,
    input  reg_addr_t address,
    output reg_data_t data
);

    // Select the addressed word; an X/Z address propagates X to the output.
    always_comb begin
        data = arrayFlat[address * DATA_W +: DATA_W];
    end

endmodule

// File: rtl/register_file_16bit_32size.sv
// 32 x 16-bit register file: one synchronous write port, two combinational read ports.
module register_file_16bit_32size
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    register_file_16bit_32size_if.slave bus
);

    logic [DEPTH-1:0][DATA_W-1:0] regArray;
    reg_flat_t                    arrayFlat;

    // Reset clears everything at once; otherwise mode alone gates the single write per edge.
    // Register 0 is an ordinary register, not hardwired to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regArray <= '0;
        end else if (bus.mode) begin
            regArray[bus.write_address] <= bus.write_value;
        end
    end

    // Reads see the stored array directly, so there is no same-cycle write bypass.
    always_comb begin
        arrayFlat = regArray;
    end

    regfile_read_port readPort1 (
        .arrayFlat (arrayFlat),
        .address   (bus.read_address1),
        .data      (bus.read_value1)
    );

    regfile_read_port readPort2 (
        .arrayFlat (arrayFlat),
        .address   (bus.read_address2),
        .data      (bus.read_value2)
    );

endmodule

// File: tb/tb_register_file_16bit_32size.sv
// Directed self-checking bench for register_file_16bit_32size.
module tb_register_file_16bit_32size;
    import regfile_pkg::*;

    logic clk;
    logic reset;
    int   nCompared;
    int   nMismatched;

    register_file_16bit_32size_if bus ();

    register_file_16bit_32size dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input reg_data_t got, input reg_data_t exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 16'h%04h, expected 16'h%04h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input reg_addr_t addr, input reg_data_t value);
        bus.mode          = 1'b1;
        bus.write_address = addr;
        bus.write_value   = value;
        tick();
        bus.mode          = 1'b0;
    endtask

    initial begin
        nCompared         = 0;
        nMismatched       = 0;
        reset             = 1'b1;
        bus.mode          = 1'b0;
        bus.write_address = '0;
        bus.write_value   = '0;
        bus.read_address1 = '0;
        bus.read_address2 = 5'd31;

        // 1: reset, then release between edges; everything reads 0.
        #12;
        checkEq("rst_hold_rd1", bus.read_value1, 16'h0000);
        checkEq("rst_hold_rd2", bus.read_value2, 16'h0000);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) begin
            bus.read_address1 = reg_addr_t'(i);
            bus.read_address2 = reg_addr_t'(31 - i);
            #1;
            checkEq($sformatf("rst_rd1_a%0d", i), bus.read_value1, 16'h0000);
            checkEq($sformatf("rst_rd2_a%0d", 31 - i), bus.read_value2, 16'h0000);
        end

        // 2: write registers 0 and 1, read them on separate ports.
        writeReg(5'd0, 16'h1232);
        writeReg(5'd1, 16'h1263);
        bus.read_address1 = 5'd0;
        bus.read_address2 = 5'd1;
        #1;
        checkEq("wr0_rd1", bus.read_value1, 16'h1232);
        checkEq("wr1_rd2", bus.read_value2, 16'h1263);

        // 3: write register 2; register 1 untouched.
        writeReg(5'd2, 16'hA06B);
        bus.read_address1 = 5'd2;
        bus.read_address2 = 5'd1;
        #1;
        checkEq("wr2_rd1", bus.read_value1, 16'hA06B);
        checkEq("keep1_rd2", bus.read_value2, 16'h1263);

        // 4: mode=0 blocks writes over several edges.
        bus.mode          = 1'b0;
        bus.write_address = 5'd3;
        bus.write_value   = 16'hFFFF;
        repeat (3) tick();
        bus.read_address1 = 5'd3;
        #1;
        checkEq("nowr3_rd1", bus.read_value1, 16'h0000);
        // Both ports on the same register.
        writeReg(5'd31, 16'h8001);
        bus.read_address1 = 5'd31;
        bus.read_address2 = 5'd31;
        #1;
        checkEq("same31_rd1", bus.read_value1, 16'h8001);
        checkEq("same31_rd2", bus.read_value2, 16'h8001);
        bus.read_address2 = 5'd0;
        #1;
        checkEq("keep0_rd2", bus.read_value2, 16'h1232);

        // 5: old value until the edge, new value right after it.
        writeReg(5'd5, 16'h0001);
        bus.read_address1 = 5'd5;
        bus.mode          = 1'b1;
        bus.write_address = 5'd5;
        bus.write_value   = 16'h00F0;
        #1;
        checkEq("pre_edge_rd1", bus.read_value1, 16'h0001);
        tick();
        bus.mode = 1'b0;
        checkEq("post_edge_rd1", bus.read_value1, 16'h00F0);

        // 6: asynchronous reset between edges, writes blocked while held.
        writeReg(5'd7, 16'h1234);
        bus.read_address1 = 5'd7;
        bus.read_address2 = 5'd31;
        #1;
        checkEq("wr7_rd1", bus.read_value1, 16'h1234);
        #1;
        reset = 1'b1;
        #1;
        checkEq("async_rst_rd1", bus.read_value1, 16'h0000);
        checkEq("async_rst_rd2", bus.read_value2, 16'h0000);
        bus.mode          = 1'b1;
        bus.write_address = 5'd7;
        bus.write_value   = 16'h5555;
        tick();
        checkEq("rst_wr_blk_rd1", bus.read_value1, 16'h0000);
        bus.mode = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        checkEq("post_rst_rd1", bus.read_value1, 16'h0000);
        bus.read_address2 = 5'd0;
        #1;
        checkEq("post_rst_rd2", bus.read_value2, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/register_file_16bit_32size.md
Name: register_file_16bit_32size

Overview:
General-purpose register file: 32 entries × 16 bits, one synchronous write port and two independent combinational read ports. It sits in the datapath between instruction decode (which supplies the register addresses) and the ALU/adder (which consumes the two read operands). The mode input selects whether the current cycle performs a write.

Parameters:
DATA_W, 16, width of each register in bits
DEPTH, 32, number of registers
ADDR_W, 5, address width; must equal clog2(DEPTH)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset; clears all registers
mode  input  1  0 = read-only cycle, 1 = write cycle
write_address  input  ADDR_W  destination register for the write port
write_value  input  DATA_W  data to write
read_address1  input  ADDR_W  register selected for read port 1
read_address2  input  ADDR_W  register selected for read port 2
read_value1  output  DATA_W  contents of register read_address1
read_value2  output  DATA_W  contents of register read_address2

Behaviour:
- Storage: DEPTH registers of DATA_W bits, indices 0..31. All are general purpose; register 0 is writable and is not hardwired to zero.
- Reset: reset high clears every register to 0 immediately, without waiting for a clock edge. While reset is high, writes are blocked and both read outputs read 0. Reset asserted mid-operation discards any pending write for that edge.
- Write: on a rising clk edge with reset low and mode = 1, write_value is stored into register[write_address]. With mode = 0, no register changes. There is exactly one write per edge, and there is no write-enable other than mode.
- Read: read_value1 and read_value2 are purely combinational functions of their addresses and the current array contents. They do not depend on mode and add zero cycles of latency. Both ports may address the same register; each then returns that register's contents.
- Write/read same register in one cycle: the read returns the old value until the rising edge, then the new value. There is no write-to-read bypass in the same cycle.
- Addresses are fully decoded. No out-of-range case exists because DEPTH = 2^ADDR_W. If X or Z appears on an address input, the corresponding read output is X; no other requirement applies.
- write_value is stored verbatim with no truncation or extension. The widths always match.
- No handshake or ready/valid signals. The block is always ready.

Decomposition:
- Package regfile_pkg: DATA_W = 16, DEPTH = 32, ADDR_W = 5, plus the typedefs reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]).
- One sub-module, regfile_read_port: a DEPTH:1 mux of width DATA_W. It takes the flattened array and an address, and returns the data. The top level instantiates it twice, once per read port.
- Top-level register array, including reset and write logic, lives in register_file_16bit_32size.

Test Plan:
1. Assert reset, then release it. Both read ports return 0 for addresses 0, 1 and 31; every register reads 0.
2. mode=1, write_address=0, write_value=16'h1232, one clk edge; then write_address=1, write_value=16'h1263, one edge. Set mode=0, read_address1=0, read_address2=1 -> read_value1=16'h1232 (4658), read_value2=16'h1263 (4707).
3. mode=1, write_address=2, write_value=16'hA06B, one edge; then mode=0, read_address1=2, read_address2=1 -> read_value1=16'hA06B (41067), read_value2=16'h1263, showing register 1 is unchanged.
4. mode=0 with write_address=3, write_value=16'hFFFF over several edges -> register 3 still reads 0. Then with read_address1=read_address2=31 after writing 16'h8001 to register 31 -> both outputs read 16'h8001.
5. Same-register timing: read_address1=5 holds 16'h0001; write 16'h00F0 to register 5 -> read_value1 stays 16'h0001 before the edge and becomes 16'h00F0 immediately after it.
6. Asynchronous reset mid-operation: write 16'h1234 to register 7, then raise reset between clock edges -> read_value1 (addr 7) drops to 0 without a clock edge. A write attempted while reset is high is ignored.
